ldpc_err_mask_gen: RTL and testbench
====================================

Name: ldpc_err_mask_gen

Overview:
- Channel-emulation stage that sits between the LDPC encoder output and the decoder's hard-decision input.
- On a start request it latches the encoded codeword. It then builds a pseudo-random error mask serially, one bit per clock, from a 32-bit Galois LFSR compared against a programmable flip threshold.
- It presents the corrupted codeword (q0_1 = codeword XOR mask) and the mask itself, then pulses done. The done pulse drives the decoder's edge-detected start_dec.
- Seed, threshold and error cap come from CSR fields.

Parameters:
- NN, 208, codeword length in bits.
- THR_W, 16, threshold width; LFSR bits [THR_W-1:0] are compared against it.
- CNT_W, $clog2(NN+1), error-counter width.

Ports:
- wb_clk_i  input  1  sole clock, rising edge.
- wb_rst_i  input  1  synchronous active-high reset.
- start  input  1  frame request; accepted only in IDLE.
- cword_in  input  NN  encoder codeword; sampled on an accepted start.
- seed_load  input  1  loads seed into the LFSR; honoured only in IDLE.
- seed  input  32  LFSR seed; value 0 is replaced by 32'h0000_0001.
- threshold  input  THR_W  per-bit flip when lfsr[THR_W-1:0] < threshold.
- max_errs  input  CNT_W  error cap per frame; 0 = unlimited.
- err_mask  output  NN  generated error mask.
- q0_1  output  NN  cword_latched XOR err_mask.
- err_count  output  CNT_W  number of 1s in err_mask.
- busy  output  1  high in GEN state.
- done  output  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset values (synchronous, wb_rst_i=1): state=IDLE; lfsr=32'h0000_0001; err_mask=0; cword_latched=0; q0_1=0; err_count=0; bit index idx=0; busy=0; done=0.
- Reset mid-GEN aborts the frame. All of the above are restored, with no done pulse.
- LFSR:
  - Galois, 32-bit, right-shifting, polynomial x^32+x^22+x^2+x+1 (feedback mask 32'h8020_0003).
  - Update when lsb=1: lfsr <= (lfsr>>1) ^ 32'h8020_0003. When lsb=0: lfsr <= lfsr>>1.
  - Advances exactly once per GEN cycle. Never advances in IDLE or DONE.
- States and transitions:
  - IDLE:
    - seed_load=1 → lfsr <= (seed==0) ? 1 : seed.
    - start=1 → cword_latched <= cword_in, err_mask <= 0, err_count <= 0, idx <= 0, go to GEN.
    - If seed_load and start are both high in the same cycle, the seed is loaded first and the frame starts from the new seed on the next cycle.
  - GEN (one cycle per bit, NN cycles total):
    - Compute flip = (lfsr[THR_W-1:0] < threshold) && (max_errs==0 || err_count < max_errs), using the pre-advance lfsr.
    - err_mask[idx] <= flip; err_count += flip; LFSR advances; idx += 1.
    - When idx==NN-1, go to DONE after this cycle.
    - start and seed_load are ignored in GEN.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Timing: start accepted at cycle 0 → busy=1 in cycles 1..NN → done=1 in cycle NN+1 → busy=0, done=0, state IDLE in cycle NN+2.
- A new start is accepted earliest in cycle NN+2.
- Outputs err_mask, q0_1 and err_count hold their values after DONE until the next accepted start.
- Comparison is strictly less-than:
  - threshold=0 → no flips ever.
  - threshold=all-ones → a flip on every bit except where lfsr[THR_W-1:0] is all-ones.
- The error cap saturates: err_count never exceeds max_errs (when nonzero). The LFSR keeps advancing once the cap is reached, so the sequence is independent of the cap.
- threshold and max_errs are sampled every GEN cycle. Software must hold them stable during a frame; behaviour is deterministic but mixed if they change mid-frame.
- The LFSR state carries over between frames unless it is reseeded.
- q0_1 is combinational from registered state: cword_latched ^ err_mask.

Test Plan:
- Reset, seed_load seed=1, threshold=0, start with cword_in=alternating 1010... → done in cycle 209; err_mask=0; err_count=0; q0_1==cword_in; busy high exactly 208 cycles.
- seed=1, threshold=16'hFFFF, max_errs=3, cword_in=0 → err_mask=208'b111 (bits 0..2 only); err_count=3; q0_1=err_mask.
- seed=32'hACE1_2345, threshold=16'h0A3D (~4%), max_errs=0 → err_mask and err_count bit-exact vs a software Galois model; two consecutive frames without reseed continue the sequence; reseeding with the same value reproduces frame 1.
- seed_load seed=0 vs seed_load seed=1, identical settings → identical err_mask.
- start and seed_load pulsed at GEN cycle 50 → ignored; done still in cycle 209; mask unchanged vs undisturbed run.
- wb_rst_i asserted at GEN cycle 100 → next cycle busy=0, err_mask=0, err_count=0, lfsr=1; no done pulse; subsequent frame matches a fresh post-reset run.

Source files
------------

// File: rtl/ldpc_err_mask_gen_if.sv
// ldpc_err_mask_gen_if: frame request/CSR inputs and mask/codeword results of the error-mask generator
//   master: start, cword_in, seed_load, seed, threshold, max_errs -> ; <- err_mask, q0_1, err_count, busy, done
//   slave : mirror of master
interface ldpc_err_mask_gen_if #(
    parameter int NN    = 208,
    parameter int THR_W = 16,
    parameter int CNT_W = $clog2(NN + 1)
);
    logic             start;
    logic [NN-1:0]    cword_in;
    logic             seed_load;
    logic [31:0]      seed;
    logic [THR_W-1:0] threshold;
    logic [CNT_W-1:0] max_errs;
    logic [NN-1:0]    err_mask;
    logic [NN-1:0]    q0_1;
    logic [CNT_W-1:0] err_count;
    logic             busy;
    logic             done;
    modport master (
        output start, cword_in, seed_load, seed, threshold, max_errs,
        input  err_mask, q0_1, err_count, busy, done
    );
    modport slave (
        input  start, cword_in, seed_load, seed, threshold, max_errs,
        output err_mask, q0_1, err_count, busy, done
    );
endinterface

// File: rtl/ldpc_err_mask_gen.sv
// ldpc_err_mask_gen: serial LFSR-driven error mask generator that corrupts a latched LDPC codeword
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   bus (slave)        : start/cword_in/seed_load/seed/threshold/max_errs in; err_mask/q0_1/err_count/busy/done out
module ldpc_err_mask_gen #(
    parameter int NN    = 208,
    parameter int THR_W = 16,
    parameter int CNT_W = $clog2(NN + 1)
) (
    input logic                wb_clk_i,
    input logic                wb_rst_i,
    ldpc_err_mask_gen_if.slave bus
);
    localparam int IDX_W = $clog2(NN + 1);
    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d, lfsr_nxt;
    logic [NN-1:0]    mask_q, mask_d, cword_q, cword_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             flip;
    // Galois step, right-shifting, taps x^32+x^22+x^2+x+1
    assign lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    // the cap gates flips only; the LFSR keeps running so the sequence is cap-independent
    assign flip = (lfsr_q[THR_W-1:0] < bus.threshold) && (bus.max_errs == '0 || cnt_q < bus.max_errs);
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        mask_d  = mask_q;
        cword_d = cword_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.seed_load) lfsr_d = (bus.seed == '0) ? 32'h1 : bus.seed;
                if (bus.start) begin
                    cword_d = bus.cword_in;
                    mask_d  = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                mask_d[idx_q] = flip;
                cnt_d         = cnt_q + CNT_W'(flip);
                lfsr_d        = lfsr_nxt;
                idx_d         = idx_q + 1'b1;
                state_d       = (idx_q == IDX_W'(NN - 1)) ? DONE : GEN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            lfsr_q  <= 32'h1;
            mask_q  <= '0;
            cword_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            mask_q  <= mask_d;
            cword_q <= cword_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end
    assign bus.err_mask  = mask_q;
    assign bus.q0_1      = cword_q ^ mask_q;
    assign bus.err_count = cnt_q;
    assign bus.busy      = (state_q == GEN);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_ldpc_err_mask_gen.sv
// tb_ldpc_err_mask_gen: scoreboard bench for ldpc_err_mask_gen against a software Galois LFSR model
module tb_ldpc_err_mask_gen;
    localparam int NN    = 208;
    localparam int THR_W = 16;
    localparam int CNT_W = $clog2(NN + 1);
    typedef struct {
        logic [NN-1:0]    mask;
        logic [CNT_W-1:0] cnt;
        logic [NN-1:0]    cw;
    } exp_t;
    logic        clk = 0;
    logic        wb_rst_i = 1;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_lfsr = 32'h1;
    exp_t        sb[$];
    ldpc_err_mask_gen_if #(.NN(NN), .THR_W(THR_W), .CNT_W(CNT_W)) bus ();
    ldpc_err_mask_gen #(.NN(NN), .THR_W(THR_W), .CNT_W(CNT_W)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(wb_rst_i),
        .bus     (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic model(input logic [NN-1:0] cw, input logic [THR_W-1:0] thr,
                         input logic [CNT_W-1:0] me, output exp_t e);
        e.mask = '0;
        e.cnt  = '0;
        e.cw   = cw;
        for (int i = 0; i < NN; i++) begin
            if (m_lfsr[THR_W-1:0] < thr && (me == 0 || e.cnt < me)) begin
                e.mask[i] = 1'b1;
                e.cnt     = e.cnt + 1'b1;
            end
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
        end
    endtask
    task automatic reseed(input logic [31:0] s);
        @(negedge clk);
        bus.seed_load = 1;
        bus.seed      = s;
        @(negedge clk);
        bus.seed_load = 0;
        m_lfsr = (s == 0) ? 32'h1 : s;
    endtask
    task automatic idle_zero(input string tag);
        chk({tag, "_busy"}, 256'(bus.busy), 256'(0));
        chk({tag, "_done"}, 256'(bus.done), 256'(0));
        chk({tag, "_mask"}, 256'(bus.err_mask), 256'(0));
        chk({tag, "_cnt"}, 256'(bus.err_count), 256'(0));
        chk({tag, "_q01"}, 256'(bus.q0_1), 256'(0));
    endtask
    task automatic frame(input string tag, input logic [NN-1:0] cw, input logic [THR_W-1:0] thr,
                         input logic [CNT_W-1:0] me, input int dist_at, input int rst_at);
        exp_t e;
        int   c = 0;
        int   bc = 0;
        bit   seen = 0;
        model(cw, thr, me, e);
        sb.push_back(e);
        @(negedge clk);
        bus.cword_in  = cw;
        bus.threshold = thr;
        bus.max_errs  = me;
        bus.start     = 1;
        while (!seen && c < 400) begin
            @(negedge clk);
            c++;
            bus.start     = 0;
            bus.seed_load = 0;
            wb_rst_i      = 0;
            if (bus.busy) bc++;
            if (bus.done) seen = 1;
            if (rst_at != 0 && c == rst_at + 1) idle_zero({tag, "_rst"});
            if (c == dist_at) begin
                bus.start     = 1;
                bus.seed_load = 1;
                bus.seed      = $urandom;
                bus.cword_in  = ~cw;
            end
            if (c == rst_at) wb_rst_i = 1;
        end
        e = sb.pop_front();
        if (rst_at != 0) begin
            chk({tag, "_nodone"}, 256'(seen), 256'(0));
            m_lfsr = 32'h1;
        end else begin
            chk({tag, "_donecyc"}, 256'(c), 256'(NN + 1));
            chk({tag, "_busycyc"}, 256'(bc), 256'(NN));
            chk({tag, "_mask"}, 256'(bus.err_mask), 256'(e.mask));
            chk({tag, "_cnt"}, 256'(bus.err_count), 256'(e.cnt));
            chk({tag, "_q01"}, 256'(bus.q0_1), 256'(e.cw ^ e.mask));
            repeat (3) @(negedge clk);
            chk({tag, "_after"}, 256'({bus.busy, bus.done}), 256'(0));
            chk({tag, "_hold"}, 256'(bus.err_mask), 256'(e.mask));
        end
    endtask
    initial begin
        logic [NN-1:0] alt;
        for (int i = 0; i < NN; i++) alt[i] = ~i[0];
        bus.start     = 0;
        bus.seed_load = 0;
        bus.seed      = 0;
        bus.cword_in  = '0;
        bus.threshold = '0;
        bus.max_errs  = '0;
        repeat (2) @(negedge clk);
        wb_rst_i = 0;
        idle_zero("reset");
        reseed(32'h1);
        frame("thr0", alt, 16'h0, 0, 0, 0);
        chk("thr0_q01_eq_cw", 256'(bus.q0_1), 256'(alt));
        reseed(32'h1);
        frame("cap3", '0, 16'hFFFF, 3, 0, 0);
        chk("cap3_mask_const", 256'(bus.err_mask), 256'(7));
        reseed(32'hACE1_2345);
        frame("rnd1", alt, 16'h0A3D, 0, 0, 0);
        frame("rnd2", ~alt, 16'h0A3D, 0, 0, 0);
        reseed(32'hACE1_2345);
        frame("rnd3", alt, 16'h0A3D, 0, 0, 0);
        reseed(32'h0);
        frame("seed0", alt, 16'h8000, 0, 0, 0);
        reseed(32'h1);
        frame("seed1", alt, 16'h8000, 0, 0, 0);
        reseed(32'h1234_5678);
        frame("dist", alt, 16'h4000, 0, 50, 0);
        reseed(32'h9E37_79B9);
        frame("rstmid", alt, 16'h4000, 0, 0, 100);
        frame("postrst", alt, 16'h0A3D, 0, 0, 0);
        frame("allones", '1, 16'hFFFF, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
